// File: rtl/umult_simd_seq_pkg.sv
// Shared control definitions for the SIMD sequential unsigned multiplier:
// element-width encodings, legal step sizes and the run-length helper.
package umult_simd_seq_pkg;

  typedef enum logic [1:0] {
    WW_8    = 2'b00,
    WW_16   = 2'b01,
    WW_32   = 2'b10,
    WW_RSVD = 2'b11
  } ww_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam int CHUNK_W = 64;
  localparam int CNT_W   = 6;

  // Multiplier bits retired per cycle may only be 1, 2, 4 or 8.
  localparam int STEP_LEGAL [4] = '{1, 2, 4, 8};

  function automatic bit step_legal(input int sb);
    return (sb == STEP_LEGAL[0]) || (sb == STEP_LEGAL[1]) ||
           (sb == STEP_LEGAL[2]) || (sb == STEP_LEGAL[3]);
  endfunction

  // Number of RUN cycles for a legal width encoding.
  function automatic logic [CNT_W-1:0] run_steps(input logic [1:0] ww, input int sb);
    return CNT_W'((32'd8 << ww) / sb);
  endfunction

endpackage

// File: rtl/umult_simd_seq_chunk64.sv
// One 64-bit slice of the datapath: shift-add multiply of every lane in
// parallel, lane layout chosen per element width, no carry between lanes.
module umult_chunk64
  import umult_simd_seq_pkg::*;
#(
  parameter int STEP_BITS = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ld_i,
  input  logic               step_i,
  input  logic               odd_i,
  input  logic [1:0]         ld_ww_i,
  input  logic [1:0]         ww_i,
  input  logic [CHUNK_W-1:0] a_i,
  input  logic [CHUNK_W-1:0] b_i,
  output logic [CHUNK_W-1:0] acc_nxt_o
);

  logic [CHUNK_W-1:0] opa_q, opb_q, acc_q;
  logic [CHUNK_W-1:0] opa_d, opb_d, a_ld_s, b_ld_s;
  logic [2:0][CHUNK_W-1:0] acc_n, opa_n, opb_n, a_ld, b_ld;

  // Each operand sits zero-extended in its own 2W-wide lane field, so the
  // multiplicand can shift left up to W-1 places without leaving the lane.
  for (genvar wi = 0; wi < 3; wi++) begin : g_w
    localparam int W  = 8 << wi;
    localparam int LW = 2 * W;
    for (genvar j = 0; j < CHUNK_W / LW; j++) begin : g_lane
      logic [LW-1:0] a_f, b_f, pp;
      assign a_f = opa_q[j*LW +: LW];
      assign b_f = opb_q[j*LW +: LW];
      always_comb begin
        pp = '0;
        for (int s = 0; s < STEP_BITS; s++)
          if (b_f[s]) pp = pp + (a_f << s);
      end
      assign acc_n[wi][j*LW +: LW] = acc_q[j*LW +: LW] + pp;
      assign opa_n[wi][j*LW +: LW] = a_f << STEP_BITS;
      assign opb_n[wi][j*LW +: LW] = b_f >> STEP_BITS;
      // Even elements occupy the upper half of the lane field, odd the lower.
      assign a_ld[wi][j*LW +: LW] = {{W{1'b0}}, odd_i ? a_i[j*LW +: W] : a_i[j*LW+W +: W]};
      assign b_ld[wi][j*LW +: LW] = {{W{1'b0}}, odd_i ? b_i[j*LW +: W] : b_i[j*LW+W +: W]};
    end
  end

  always_comb begin
    acc_nxt_o = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    case (ww_i)
      WW_8:    begin acc_nxt_o = acc_n[0]; opa_d = opa_n[0]; opb_d = opb_n[0]; end
      WW_16:   begin acc_nxt_o = acc_n[1]; opa_d = opa_n[1]; opb_d = opb_n[1]; end
      WW_32:   begin acc_nxt_o = acc_n[2]; opa_d = opa_n[2]; opb_d = opb_n[2]; end
      default: ;
    endcase
  end

  always_comb begin
    a_ld_s = '0;
    b_ld_s = '0;
    case (ld_ww_i)
      WW_8:    begin a_ld_s = a_ld[0]; b_ld_s = b_ld[0]; end
      WW_16:   begin a_ld_s = a_ld[1]; b_ld_s = b_ld[1]; end
      WW_32:   begin a_ld_s = a_ld[2]; b_ld_s = b_ld[2]; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opa_q <= '0;
      opb_q <= '0;
      acc_q <= '0;
    end else if (ld_i) begin
      opa_q <= a_ld_s;
      opb_q <= b_ld_s;
      acc_q <= '0;
    end else if (step_i) begin
      opa_q <= opa_d;
      opb_q <= opb_d;
      acc_q <= acc_nxt_o;
    end
  end

endmodule

// File: rtl/umult_simd_seq.sv
// SIMD sequential unsigned multiplier: one FSM and step counter driving
// DATA_W/64 chunk datapaths; results are double-width products per lane.
module umult_simd_seq
  import umult_simd_seq_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int STEP_BITS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [0:1]        ctrl_ww,
  input  logic              ctrl_odd,
  input  logic [0:DATA_W-1] reg_A,
  input  logic [0:DATA_W-1] reg_B,
  output logic              busy,
  output logic              done,
  output logic [0:DATA_W-1] result
);

  localparam int NCHUNK = DATA_W / CHUNK_W;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        ww_q, ww_d, ww_in;
  logic [0:DATA_W-1] result_q, result_d, acc_nxt;
  logic              ld, step, last;

  assign ww_in = ctrl_ww;
  assign last  = (cnt_q == run_steps(ww_q, STEP_BITS) - CNT_W'(1));

  for (genvar c = 0; c < NCHUNK; c++) begin : g_chunk
    umult_chunk64 #(.STEP_BITS(STEP_BITS)) u_chunk (
      .clk       (clk),
      .reset     (reset),
      .ld_i      (ld),
      .step_i    (step),
      .odd_i     (ctrl_odd),
      .ld_ww_i   (ww_in),
      .ww_i      (ww_q),
      .a_i       (reg_A[c*CHUNK_W +: CHUNK_W]),
      .b_i       (reg_B[c*CHUNK_W +: CHUNK_W]),
      .acc_nxt_o (acc_nxt[c*CHUNK_W +: CHUNK_W])
    );
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ww_d     = ww_q;
    result_d = result_q;
    ld       = 1'b0;
    step     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ww_d = ww_in;
          if (ww_in == WW_RSVD) begin
            state_d  = S_DONE;
            result_d = '0;
          end else begin
            state_d = S_RUN;
            cnt_d   = '0;
            ld      = 1'b1;
          end
        end
      end
      S_RUN: begin
        step = 1'b1;
        // The final step's sum goes straight into the result register.
        if (last) begin
          state_d  = S_DONE;
          result_d = acc_nxt;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ww_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ww_q     <= ww_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_umult_simd_seq.sv
// Directed and randomized bench for umult_simd_seq (DATA_W=128, STEP_BITS=2)
// against a lane-by-lane arithmetic reference model.
module tb_umult_simd_seq;

  localparam int DW   = 128;
  localparam int STEP = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [0:1]    ctrl_ww;
  logic          ctrl_odd;
  logic [0:DW-1] reg_A, reg_B;
  logic          busy, done;
  logic [0:DW-1] result;

  int n_vec = 0;
  int n_bad = 0;
  logic [0:DW-1] last_res;

  umult_simd_seq #(.DATA_W(DW), .STEP_BITS(STEP)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .ctrl_ww  (ctrl_ww),
    .ctrl_odd (ctrl_odd),
    .reg_A    (reg_A),
    .reg_B    (reg_B),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:DW-1] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference: pick element k of each operand by bit position, multiply as
  // plain integers, place the 2W-bit product into lane k (bit 0 = MSB).
  function automatic logic [0:DW-1] ref_mul(input logic [1:0] ww, input logic odd,
                                            input logic [0:DW-1] a, input logic [0:DW-1] b);
    logic [0:DW-1] r;
    logic [63:0]   ea, eb, p;
    int            w, base, off;
    r = '0;
    if (ww == 2'b11) return r;
    w   = 8 << ww;
    off = odd ? w : 0;
    for (int k = 0; k < DW / (2 * w); k++) begin
      base = 2 * k * w;
      ea = '0;
      eb = '0;
      for (int i = 0; i < w; i++) begin
        ea = {ea[62:0], a[base + off + i]};
        eb = {eb[62:0], b[base + off + i]};
      end
      p = ea * eb;
      for (int i = 0; i < 2 * w; i++) r[base + i] = p[2*w - 1 - i];
    end
    return r;
  endfunction

  // Issue one operation and watch 40 cycles: busy/done/result every cycle.
  // Operands are scrambled after capture; with poke, start is re-pulsed
  // while the block is busy.
  task automatic do_op(input logic [1:0] ww, input logic odd,
                       input logic [0:DW-1] a, input logic [0:DW-1] b, input bit poke);
    logic [0:DW-1] exp;
    int            exp_lat;
    exp     = ref_mul(ww, odd, a, b);
    exp_lat = (ww == 2'b11) ? 1 : (8 << ww) / STEP + 1;
    @(negedge clk);
    start = 1'b1; ctrl_ww = ww; ctrl_odd = odd; reg_A = a; reg_B = b;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start    = poke && (c < exp_lat) && (c % 2 == 1);
      reg_A    = rnd128();
      reg_B    = rnd128();
      ctrl_odd = 1'($urandom_range(1, 0));
      ctrl_ww  = 2'($urandom_range(3, 0));
      chk("busy", {127'd0, busy}, {127'd0, (c <= exp_lat)});
      chk("done", {127'd0, done}, {127'd0, (c == exp_lat)});
      chk((c < exp_lat) ? "result_hold" : "result", result, (c < exp_lat) ? last_res : exp);
    end
    start = 1'b0;
    last_res = exp;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ctrl_ww = 2'b00; ctrl_odd = 1'b0;
    reg_A = '0; reg_B = '0; last_res = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_done", {127'd0, done}, 128'd0);
    chk("rst_result", result, 128'd0);
    reset = 1'b0;

    // w8 even, 0xFF * 0xFF in lane 0
    do_op(2'b00, 1'b0, {8'hFF, 120'h0}, {8'hFF, 120'h0}, 1'b0);
    chk("w8_ff", result, {16'hFE01, 112'h0});

    // w16 odd; even halfwords carry junk that must be ignored
    do_op(2'b01, 1'b1, {16'hABCD, 16'h1234, 96'h0}, {16'h5555, 16'h0010, 96'h0}, 1'b0);
    chk("w16_odd", result, {32'h00012340, 96'h0});

    // w32 even, max operands in lane 0 and 3*5 in lane 1
    do_op(2'b10, 1'b0, {32'hFFFFFFFF, 32'h0, 32'h3, 32'h0},
                       {32'hFFFFFFFF, 32'h0, 32'h5, 32'h0}, 1'b0);
    chk("w32_max", result, 128'hFFFFFFFE00000001_000000000000000F);

    // reserved width: one-cycle turnaround, zero result
    do_op(2'b11, 1'b0, {128{1'b1}}, {128{1'b1}}, 1'b0);
    chk("rsvd_zero", result, 128'h0);

    // start re-pulsed with new operands during RUN must be ignored
    do_op(2'b00, 1'b1, rnd128(), rnd128(), 1'b1);
    do_op(2'b10, 1'b1, rnd128(), rnd128(), 1'b1);

    // all-ones in every width exercise the full per-lane carry chain
    for (int w = 0; w < 3; w++)
      do_op(2'(w), 1'(w % 2), {128{1'b1}}, {128{1'b1}}, 1'b0);

    for (int i = 0; i < 18; i++)
      do_op(2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), rnd128(), rnd128(), 1'(i % 3 == 0));

    // reset in RUN cycle 3 aborts the operation
    @(negedge clk);
    start = 1'b1; ctrl_ww = 2'b00; ctrl_odd = 1'b0;
    reg_A = {8'h7F, 120'h0}; reg_B = {8'h09, 120'h0};
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", {127'd0, busy}, 128'd0);
    chk("abort_done", {127'd0, done}, 128'd0);
    chk("abort_result", result, 128'd0);
    @(negedge clk);
    reset = 1'b0;
    last_res = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("abort_no_done", {127'd0, done}, 128'd0);
    end
    do_op(2'b00, 1'b0, {8'h03, 120'h0}, {8'h04, 120'h0}, 1'b0);
    chk("post_reset_3x4", {112'h0, result[0:15]}, 128'h000C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/umult_simd_seq.md
UMULT_SIMD_SEQ -- requirements
Module: umult_simd_seq

Interface
REQ-001 Parameter DATA_W, default 128, meaning vector register width in bits; SHALL be a multiple of 64.
REQ-002 Parameter STEP_BITS, default 2, meaning multiplier bits retired per cycle; SHALL be one of 1, 2, 4, 8.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request a new multiply; sampled only in IDLE.
REQ-006 ctrl_ww  input  [0:1]  element width: 00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = reserved.
REQ-007 ctrl_odd  input  1  0 selects even-indexed source elements, 1 selects odd-indexed elements.
REQ-008 reg_A, reg_B  input  [0:DATA_W-1]  operands; bit 0 is MSB.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  single-cycle pulse when result becomes valid.
REQ-011 result  output  [0:DATA_W-1]  packed double-width products.

Function
REQ-012 Element width W = 8/16/32 per ctrl_ww; source element k spans bits [2kW + ctrl_odd*W : 2kW + ctrl_odd*W + W-1] of reg_A and reg_B.
REQ-013 Result lane k spans bits [2kW : 2kW+2W-1] = unsigned A_k * B_k, exact, no truncation or saturation.
REQ-014 FSM states IDLE, RUN, DONE; IDLE->RUN on start (except REQ-017); RUN->DONE after the last step; DONE->IDLE unconditionally after one cycle.
REQ-015 On leaving IDLE, the block SHALL capture reg_A, reg_B, ctrl_ww and ctrl_odd; later input changes SHALL NOT affect the operation.
REQ-016 RUN SHALL last exactly W/STEP_BITS cycles; each cycle adds STEP_BITS partial products, LSB-first, into every lane in parallel.
REQ-017 ctrl_ww = 11 with start: IDLE->DONE directly; result = 0.
REQ-018 busy = 1 in RUN and DONE; done = 1 only in DONE.
REQ-019 Start-to-done latency = W/STEP_BITS + 1 cycles; with STEP_BITS = 2 this is 5/9/17 cycles for W = 8/16/32.
REQ-020 start while busy SHALL be ignored; no queuing.
REQ-021 result SHALL update only on entry to DONE and SHALL hold until the next DONE or reset.
REQ-022 Accumulation SHALL NOT carry across lane boundaries.

Reset
REQ-023 reset SHALL force IDLE; busy = 0, done = 0, result = 0, and clear all internal accumulators, operand copies and the step counter.
REQ-024 Reset during RUN or DONE SHALL abort the operation; no done pulse follows.
REQ-025 The first start after reset deasserts SHALL be honoured normally.

Structure
REQ-026 ctrl_ww encodings (w8, w16, w32, reserved) and the legal STEP_BITS values SHALL live in the shared control header/package.
REQ-027 Sub-module umult_chunk64 SHALL implement the per-64-bit-chunk datapath in all three widths; it is instantiated DATA_W/64 times under a single shared FSM and counter.

Verification
REQ-028 DATA_W = 128, STEP_BITS = 2, w8 even, A[0:7] = B[0:7] = 0xFF -> result[0:15] = 0xFE01; done in cycle 5 after start.
REQ-029 w16 odd, A[16:31] = 0x1234, B[16:31] = 0x0010 -> result[0:31] = 0x00012340; all even halfwords ignored; done in cycle 9.
REQ-030 w32 even, A[0:31] = B[0:31] = 0xFFFFFFFF and A[64:95] = 3, B[64:95] = 5 -> result = 0xFFFFFFFE00000001_000000000000000F; done in cycle 17.
REQ-031 ctrl_ww = 11 with nonzero operands -> done in cycle 1 and result = 0.
REQ-032 start pulses during RUN with changed operands -> ignored; the original result is produced; exactly one done pulse.
REQ-033 reset asserted in RUN cycle 3 -> busy/done/result = 0 immediately; no done pulse; a subsequent w8 3x4 yields 0x000C.
